// File: rtl/axis_fifo_if.sv
// AXI-Stream link bundle: data, frame-end flag and valid/ready handshake.
// Latency: none, wires only.
// Backpressure: the sink drives tready; the source holds tvalid/tdata/tlast until accepted.
interface axis_fifo_if #(
  parameter int width = 1
);
  logic [width-1:0] tdata;
  logic             tvalid;
  logic             tlast;
  logic             tready;

  // Source side of the link: drives the word, receives ready.
  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  // Sink side of the link: receives the word, drives ready.
  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_fifo.sv
// First-word-fall-through AXI-Stream FIFO storing {tlast, tdata}, with word and frame occupancy.
// Latency: a word pushed at edge N is presented on m_axis after edge N; one push and one pop per cycle.
// Backpressure: s_axis.tready = !full && !rst; no combinational path from m_axis.tready to s_axis.tready.
module axis_fifo #(
  parameter int width = 1,
  parameter int depth = 16,
  localparam int aw = $clog2(depth)
) (
  input  logic            clk,
  input  logic            rst,
  axis_fifo_if.slave      s_axis,
  axis_fifo_if.master     m_axis,
  output logic [aw:0]     data_count,
  output logic [aw:0]     frame_count,
  output logic            full,
  output logic            empty
);

  localparam logic [aw:0]   cnt_one   = (aw+1)'(1);
  localparam logic [aw:0]   cnt_depth = (aw+1)'(depth);
  localparam logic [aw-1:0] ptr_one   = aw'(1);

  logic [width:0]  mem [depth];
  logic [aw-1:0]   wr_ptr;
  logic [aw-1:0]   rd_ptr;
  logic [width:0]  head;
  logic            push;
  logic            pop;
  logic            push_last;
  logic            pop_last;
  logic [aw:0]     count_nxt;
  logic [aw:0]     frame_nxt;

  // Handshake outputs come only from registered state (and rst for tready).
  assign s_axis.tready = !full && !rst;
  assign m_axis.tvalid = !empty;
  assign head          = mem[rd_ptr];
  assign m_axis.tdata  = head[width-1:0];
  assign m_axis.tlast  = head[width];

  assign push      = s_axis.tvalid && s_axis.tready;
  assign pop       = m_axis.tvalid && m_axis.tready;
  assign push_last = push && s_axis.tlast;
  assign pop_last  = pop && head[width];

  // Next occupancy: a simultaneous push and pop cancel out for both counters.
  always_comb begin
    count_nxt = data_count;
    frame_nxt = frame_count;
    if (push && !pop) begin
      count_nxt = data_count + cnt_one;
    end else if (pop && !push) begin
      count_nxt = data_count - cnt_one;
    end
    if (push_last && !pop_last) begin
      frame_nxt = frame_count + cnt_one;
    end else if (pop_last && !push_last) begin
      frame_nxt = frame_count - cnt_one;
    end
  end

  // Storage array; contents are deliberately not reset, pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_axis.tlast, s_axis.tdata};
    end
  end

  // Pointers, counters and registered status flags; reset discards all stored words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      data_count  <= '0;
      frame_count <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_one;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_one;
      end
      data_count  <= count_nxt;
      frame_count <= frame_nxt;
      full        <= (count_nxt == cnt_depth);
      empty       <= (count_nxt == '0);
    end
  end

endmodule

// File: tb/tb_axis_fifo.sv
// Self-checking bench for axis_fifo (width 4, depth 16) driven by directed steps and a scoreboard.
// Latency: each step drives at the falling edge, checks outputs, then checks registered state after the rising edge.
// Backpressure: expected tready/tvalid come from the bench's own occupancy model, never from the DUT.
module tb_axis_fifo;

  localparam int W = 4;
  localparam int D = 16;
  localparam int AW = $clog2(D);

  logic clk;
  logic rst;
  logic [AW:0] data_count;
  logic [AW:0] frame_count;
  logic full;
  logic empty;

  axis_fifo_if #(.width(W)) s_if ();
  axis_fifo_if #(.width(W)) m_if ();

  axis_fifo #(.width(W), .depth(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_axis      (s_if.slave),
    .m_axis      (m_if.master),
    .data_count  (data_count),
    .frame_count (frame_count),
    .full        (full),
    .empty       (empty)
  );

  int checks = 0;
  int errors = 0;
  logic [W:0] sb [$];
  int mfc = 0;
  int pushed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; returns at the next falling edge.
  task automatic step(input logic v, input logic l, input logic [W-1:0] d, input logic r);
    logic do_push;
    logic do_pop;
    logic [W:0] hd;
    s_if.tvalid = v;
    s_if.tlast  = l;
    s_if.tdata  = d;
    m_if.tready = r;
    #1;
    do_push = v && (sb.size() < D);
    do_pop  = r && (sb.size() > 0);
    check("s_tready", {31'b0, s_if.tready}, (sb.size() < D) ? 32'd1 : 32'd0);
    check("m_tvalid", {31'b0, m_if.tvalid}, (sb.size() > 0) ? 32'd1 : 32'd0);
    if (sb.size() > 0) begin
      hd = sb[0];
      check("m_tdata", {28'b0, m_if.tdata}, {28'b0, hd[W-1:0]});
      check("m_tlast", {31'b0, m_if.tlast}, {31'b0, hd[W]});
    end
    @(posedge clk);
    if (do_pop) begin
      hd = sb.pop_front();
      if (hd[W]) mfc--;
    end
    if (do_push) begin
      sb.push_back({l, d});
      if (l) mfc++;
      pushed++;
    end
    @(negedge clk);
    check("data_count", {27'b0, data_count}, sb.size());
    check("frame_count", {27'b0, frame_count}, mfc);
    check("full", {31'b0, full}, (sb.size() == D) ? 32'd1 : 32'd0);
    check("empty", {31'b0, empty}, (sb.size() == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;
    #3;
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_m_tvalid", {31'b0, m_if.tvalid}, 32'd0);
    check("rst_s_tready", {31'b0, s_if.tready}, 32'd0);
    check("rst_data_count", {27'b0, data_count}, 32'd0);
    check("rst_frame_count", {27'b0, frame_count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_s_tready", {31'b0, s_if.tready}, 32'd1);

    // Single word, then pop it.
    step(1'b1, 1'b1, 4'h5, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b1);

    // Fill to full, then offer a 17th word that must be refused.
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'(i), 1'b0);
    step(1'b1, 1'b1, 4'hF, 1'b0);

    // Single pop at full, then sustained push+pop across pointer wrap.
    step(1'b0, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'(i % 3 == 0), W'(i + 3), 1'b1);

    // Drain; order is checked against the scoreboard on every step.
    for (int i = 0; i < 2 * D && sb.size() > 0; i++) step(1'b0, 1'b0, 4'h0, 1'b1);
    check("drain_empty", sb.size(), 32'd0);

    // Random valid, ready and tlast.
    pushed = 0;
    for (int c = 0; c < 5000 && pushed < 1000; c++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
    end
    check("rand_pushed", pushed, 32'd1000);
    for (int i = 0; i < 2 * D && sb.size() > 0; i++) step(1'b0, 1'b0, 4'h0, 1'b1);

    // Reset mid-frame discards everything immediately.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'(i + 1), 1'b0);
    s_if.tvalid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_m_tvalid", {31'b0, m_if.tvalid}, 32'd0);
    check("midrst_s_tready", {31'b0, s_if.tready}, 32'd0);
    check("midrst_empty", {31'b0, empty}, 32'd1);
    sb.delete();
    mfc = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_data_count", {27'b0, data_count}, 32'd0);
    check("post_frame_count", {27'b0, frame_count}, 32'd0);
    check("post_empty", {31'b0, empty}, 32'd1);
    check("post_m_tvalid", {31'b0, m_if.tvalid}, 32'd0);
    step(1'b1, 1'b1, 4'hA, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b1);

    // Empty edge with tready held high: alternate push/idle, then back-to-back pushes at count 1.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'(i % 2), W'(i + 8), 1'b1);
      step(1'b0, 1'b0, 4'h0, 1'b1);
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'(i % 2), W'(i + 2), 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check("final_empty", {31'b0, empty}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
